// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Control-unit FSM for the multicycle MIPS core. Sequences each instruction
// through FETCH/DECODE/... states, sharing one memory port and one ALU, and
// stretches every memory access by MEM_LAT wait cycles.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset (all outputs 0 while low)
//   OPCode     in   instr[31:26]
//   Funct      in   instr[5:0]
//   Z          in   ALU zero flag
//   IorD       out  memory address select (0=PC, 1=ALUOut)
//   MemWrite   out  data memory write strobe
//   IRWrite    out  instruction register load
//   RegDst     out  write register select (0=rt, 1=rd)
//   MemtoReg   out  writeback select (0=ALUOut, 1=mem data)
//   RegWr      out  register file write enable
//   ALUSrcA    out  ALU A select (0=PC, 1=rs)
//   ALUSrcB    out  ALU B select (00=rt, 01=4, 10=SignImm, 11=SignImm<<2)
//   ALUCtrl    out  ALU operation
//   PCSrc      out  PC source (00=ALUResult, 01=ALUOut, 10=jump target)
//   PCEn       out  PC load enable
//   illegal    out  pulse in DECODE on unsupported opcode/funct
//   instrDone  out  pulse on the final cycle of each instruction
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int unsigned MEM_LAT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCode,
    input  logic [5:0] Funct,
    input  logic       Z,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWr,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUCtrl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       illegal,
    output logic       instrDone
);

    localparam int unsigned WAIT_W = 4;
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_LAT);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WAIT_W-1:0]  r_wait;
    logic [WAIT_W-1:0]  w_wait_next;
    logic               w_last;
    logic               w_wait_state;
    logic               w_funct_ok;

    // State and memory wait counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
        end
    end

    // Wait counter runs only in memory states and clears on the last wait cycle
    always_comb begin
        w_last       = (r_wait == LAST_WAIT);
        w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
        w_wait_next  = '0;
        if (w_wait_state && !w_last) begin
            w_wait_next = r_wait + WAIT_W'(1);
        end
        w_funct_ok = (Funct == FN_ADD) || (Funct == FN_SUB) || (Funct == FN_AND) ||
                     (Funct == FN_OR)  || (Funct == FN_SLT);
    end

    // Next-state and Moore outputs (PCEn in BRANCH follows Z directly)
    always_comb begin
        w_next    = S_FETCH;
        IorD      = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWr     = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUCtrl   = 3'b000;
        PCSrc     = 2'b00;
        PCEn      = 1'b0;
        illegal   = 1'b0;
        instrDone = 1'b0;

        case (r_state)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                ALUCtrl = ALU_ADD;
                if (w_last) begin
                    IRWrite = 1'b1;
                    PCEn    = 1'b1;
                    w_next  = S_DECODE;
                end else begin
                    w_next  = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                ALUCtrl = ALU_ADD;
                case (OPCode)
                    OP_R: begin
                        if (w_funct_ok) begin
                            w_next = S_EXEC;
                        end else begin
                            illegal   = 1'b1;
                            instrDone = 1'b1;
                        end
                    end
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        illegal   = 1'b1;
                        instrDone = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUCtrl = ALU_ADD;
                w_next  = (OPCode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD   = 1'b1;
                w_next = w_last ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                MemtoReg  = 1'b1;
                RegWr     = 1'b1;
                instrDone = 1'b1;
            end
            S_MEMWR: begin
                IorD = 1'b1;
                if (w_last) begin
                    MemWrite  = 1'b1;
                    instrDone = 1'b1;
                end else begin
                    w_next = S_MEMWR;
                end
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                w_next  = S_ALUWB;
                case (Funct)
                    FN_SUB:  ALUCtrl = ALU_SUB;
                    FN_AND:  ALUCtrl = ALU_AND;
                    FN_OR:   ALUCtrl = ALU_OR;
                    FN_SLT:  ALUCtrl = ALU_SLT;
                    default: ALUCtrl = ALU_ADD;
                endcase
            end
            S_ALUWB: begin
                RegDst    = 1'b1;
                RegWr     = 1'b1;
                instrDone = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA   = 1'b1;
                ALUCtrl   = ALU_SUB;
                PCSrc     = 2'b01;
                PCEn      = Z;
                instrDone = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUCtrl = ALU_ADD;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWr     = 1'b1;
                instrDone = 1'b1;
            end
            S_JUMP: begin
                PCSrc     = 2'b10;
                PCEn      = 1'b1;
                instrDone = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase

        // No strobes of any kind while reset is held
        if (!reset) begin
            IorD      = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            RegDst    = 1'b0;
            MemtoReg  = 1'b0;
            RegWr     = 1'b0;
            ALUSrcA   = 1'b0;
            ALUSrcB   = 2'b00;
            ALUCtrl   = 3'b000;
            PCSrc     = 2'b00;
            PCEn      = 1'b0;
            illegal   = 1'b0;
            instrDone = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench: two controller instances (MEM_LAT=0 and MEM_LAT=2), one
// active at a time while the other is held in reset. A reference model expands
// each instruction into its expected per-cycle control vector list.
// Vector layout: {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWr,ALUSrcA,
//                 ALUSrcB[1:0],ALUCtrl[2:0],PCSrc[1:0],PCEn,illegal,instrDone}
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst0;
    logic        rst2;
    logic [5:0]  opc;
    logic [5:0]  fct;
    logic        z;
    wire  [16:0] obs0;
    wire  [16:0] obs2;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cur_lat  = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_LAT(0)) dut0 (
        .clk(clk), .reset(rst0), .OPCode(opc), .Funct(fct), .Z(z),
        .IorD(obs0[16]), .MemWrite(obs0[15]), .IRWrite(obs0[14]), .RegDst(obs0[13]),
        .MemtoReg(obs0[12]), .RegWr(obs0[11]), .ALUSrcA(obs0[10]), .ALUSrcB(obs0[9:8]),
        .ALUCtrl(obs0[7:5]), .PCSrc(obs0[4:3]), .PCEn(obs0[2]), .illegal(obs0[1]),
        .instrDone(obs0[0])
    );

    multicycle_ctrl #(.MEM_LAT(2)) dut2 (
        .clk(clk), .reset(rst2), .OPCode(opc), .Funct(fct), .Z(z),
        .IorD(obs2[16]), .MemWrite(obs2[15]), .IRWrite(obs2[14]), .RegDst(obs2[13]),
        .MemtoReg(obs2[12]), .RegWr(obs2[11]), .ALUSrcA(obs2[10]), .ALUSrcB(obs2[9:8]),
        .ALUCtrl(obs2[7:5]), .PCSrc(obs2[4:3]), .PCEn(obs2[2]), .illegal(obs2[1]),
        .instrDone(obs2[0])
    );

    function automatic logic [16:0] v(input logic iord, mw, irw, rdst, m2r, rw, sa,
                                      input logic [1:0] sb, input logic [2:0] ac,
                                      input logic [1:0] ps, input logic pe, il, dn);
        return {iord, mw, irw, rdst, m2r, rw, sa, sb, ac, ps, pe, il, dn};
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) ||
                                (fn == 6'h25) || (fn == 6'h2A);
        return (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h08) || (op == 6'h02);
    endfunction

    // Reference model: expected control vector for every cycle of one instruction
    function automatic void build(input int lat, input logic [5:0] op, input logic [5:0] fn,
                                  input logic zz);
        exp_q.delete();
        for (int i = 0; i < lat; i++) exp_q.push_back(v(0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0,0));
        exp_q.push_back(v(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0,0));
        if (!is_legal(op, fn)) begin
            exp_q.push_back(v(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,1,1));
            return;
        end
        exp_q.push_back(v(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0,0));
        case (op)
            6'h23: begin
                exp_q.push_back(v(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,0));
                for (int i = 0; i <= lat; i++) exp_q.push_back(v(1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0));
                exp_q.push_back(v(0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0,0,1));
            end
            6'h2B: begin
                exp_q.push_back(v(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,0));
                for (int i = 0; i < lat; i++) exp_q.push_back(v(1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0));
                exp_q.push_back(v(1,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,1));
            end
            6'h00: begin
                exp_q.push_back(v(0,0,0,0,0,0,1,2'b00,alu_of(fn),2'b00,0,0,0));
                exp_q.push_back(v(0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0,0,1));
            end
            6'h04: exp_q.push_back(v(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,zz,0,1));
            6'h08: begin
                exp_q.push_back(v(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,0));
                exp_q.push_back(v(0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0,0,1));
            end
            default: exp_q.push_back(v(0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1,0,1));
        endcase
    endfunction

    // Make the selected instance the active one (called just after a rising edge)
    task automatic activate(input int lat);
        if (lat != cur_lat) begin
            if (lat == 0) begin rst2 = 1'b0; rst0 = 1'b1; end
            else          begin rst0 = 1'b0; rst2 = 1'b1; end
            cur_lat = lat;
        end
    endtask

    // Compare the first n expected vectors, one per cycle, sampled on the falling edge
    task automatic check_seq(input string name, input int lat, input int n);
        logic [16:0] got;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            got = (lat == 0) ? obs0 : obs2;
            n_checks++;
            if (got !== exp_q[i])
                $display("FAIL %s lat%0d cyc%0d: got %05h expected %05h", name, lat, i, got, exp_q[i]);
            else
                n_pass++;
            n_checks++;
            if ((32'(got[15]) + 32'(got[14]) + 32'(got[11])) > 1)
                $display("FAIL %s lat%0d cyc%0d strobes: got %05h expected at most one write", name, lat, i, got);
            else
                n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_instr(input string name, input int lat, input logic [5:0] op,
                             input logic [5:0] fn, input logic zz);
        activate(lat);
        opc = op; fct = fn; z = zz;
        build(lat, op, fn, zz);
        check_seq(name, lat, exp_q.size());
    endtask

    task automatic check_zero(input string name, input int lat);
        logic [16:0] got;
        @(negedge clk);
        got = (lat == 0) ? obs0 : obs2;
        n_checks++;
        if (got !== 17'h0) $display("FAIL %s lat%0d: got %05h expected 00000", name, lat, got);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst0 = 1'b0; rst2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks += 2;
            if (obs0 !== 17'h0) $display("FAIL reset0 cyc%0d: got %05h expected 00000", i, obs0);
            else n_pass++;
            if (obs2 !== 17'h0) $display("FAIL reset2 cyc%0d: got %05h expected 00000", i, obs2);
            else n_pass++;
            @(posedge clk); #1;
        end
        rst0 = 1'b1;
        cur_lat = 0;
    endtask

    task automatic test_rtype();
        run_instr("r_slt", 0, 6'h00, 6'h2A, 1'b0);
        run_instr("r_add", 0, 6'h00, 6'h20, 1'b1);
        run_instr("r_sub", 2, 6'h00, 6'h22, 1'b0);
        run_instr("r_or",  0, 6'h00, 6'h25, 1'b0);
    endtask

    task automatic test_mem();
        run_instr("lw",   2, 6'h23, 6'h00, 1'b0);
        run_instr("sw",   0, 6'h2B, 6'h11, 1'b0);
        run_instr("lw0",  0, 6'h23, 6'h3F, 1'b1);
        run_instr("sw2",  2, 6'h2B, 6'h00, 1'b0);
        run_instr("addi", 0, 6'h08, 6'h00, 1'b0);
    endtask

    task automatic test_branch_jump();
        run_instr("beq_t",  0, 6'h04, 6'h00, 1'b1);
        run_instr("beq_nt", 0, 6'h04, 6'h00, 1'b0);
        run_instr("beq_t2", 2, 6'h04, 6'h00, 1'b1);
        run_instr("j",      0, 6'h02, 6'h00, 1'b0);
    endtask

    task automatic test_illegal();
        run_instr("ill_op",  0, 6'h3F, 6'h20, 1'b0);
        run_instr("ill_fn",  2, 6'h00, 6'h21, 1'b0);
        run_instr("after",   0, 6'h00, 6'h24, 1'b0);
    endtask

    // Reset dropped during the final MEMWR cycle must suppress the write strobe
    task automatic test_reset_abort();
        activate(2);
        opc = 6'h2B; fct = 6'h00; z = 1'b0;
        build(2, 6'h2B, 6'h00, 1'b0);
        check_seq("sw_abort", 2, exp_q.size() - 1);
        rst2 = 1'b0;
        check_zero("abort_memwr", 2);
        check_zero("abort_hold", 2);
        rst2 = 1'b1;
        run_instr("restart", 2, 6'h00, 6'h20, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] op;
        logic [5:0] fn;
        int         lat;
        logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        for (int k = 0; k < 60; k++) begin
            lat = ($urandom_range(0, 1) == 0) ? 0 : 2;
            fn  = 6'($urandom);
            case ($urandom_range(0, 7))
                0: begin op = 6'h00; fn = fns[$urandom_range(0, 4)]; end
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                4: op = 6'h08;
                5: op = 6'h02;
                6: op = 6'($urandom);
                default: op = 6'h00;
            endcase
            run_instr("rand", lat, op, fn, 1'($urandom));
        end
    endtask

    initial begin
        rst0 = 1'b0; rst2 = 1'b0;
        opc = 6'h00; fct = 6'h00; z = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_rtype();
        test_mem();
        test_branch_jump();
        test_illegal();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
